uart_program_loader: RTL and testbench

- Boot-time stage that sits directly upstream of the CPU's program memory.
- Receives a framed program image over a UART RX line and assembles little-endian 32-bit words.
- Writes each word into the program-memory BRAM write port (wr_addr/ram_in/byte_w_en).
- Holds the CPU in reset until a complete image with a valid checksum has been stored.

---
 rtl/loader_pkg.sv | 26 ++
 rtl/uart_rx.sv | 118 +++++++++++
 rtl/uart_program_loader.sv | 167 ++++++++++++++++
 tb/tb_uart_program_loader.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared constants and state encodings for the UART program loader and its receiver.
package loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         LANE_W    = 2;

    typedef logic [LANE_W-1:0] lane_t;

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        CSUM,
        DONE,
        ERROR
    } load_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// UART 8N1 receiver: 2-flop synchroniser, mid-bit sampling, one-cycle byte_valid / framing_err strobes.
module uart_rx
    import loader_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int BAUD        = 115200
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       framing_err_o
);

    localparam int DIV   = CLK_FREQ_HZ / BAUD;
    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(DIV - 1);

    logic [1:0]       sync_q;
    logic             prev_q;
    logic             rx_s;
    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       byte_q, byte_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx_i};
            prev_q  <= rx_s;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (prev_q && !rx_s) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                // A start bit that is already gone at mid-bit is line noise.
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    if (rx_s) begin
                        byte_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign byte_o        = byte_q;
    assign byte_valid_o  = valid_q;
    assign framing_err_o = ferr_q;

endmodule

// File: rtl/uart_program_loader.sv
// Boot loader: receives a framed image over UART, writes 32-bit words to program memory and releases the CPU on a good checksum.
// Define LOADER_RELOAD_EN to let a sync byte received in DONE start a fresh load.
module uart_program_loader
    import loader_pkg::*;
#(
    parameter int CLK_FREQ_HZ     = 100000000,
    parameter int BAUD            = 115200,
    parameter int PMEM_ADDR_WIDTH = 12
) (
    input  logic                       sysclk,
    input  logic                       rst,
    input  logic                       uart_rx,
    output logic [PMEM_ADDR_WIDTH-1:0] pmem_wr_addr,
    output logic [31:0]                pmem_wr_data,
    output logic [3:0]                 pmem_byte_w_en,
    output logic                       cpu_rst,
    output logic                       load_done,
    output logic                       load_error
);

    localparam logic [16:0] CAPACITY = 17'(2 ** PMEM_ADDR_WIDTH);

    logic [7:0]                 rx_byte;
    logic                       rx_valid;
    logic                       rx_ferr;

    load_state_t                state_q, state_d;
    logic [15:0]                len_q, len_d;
    logic [16:0]                wcnt_q, wcnt_d;
    lane_t                      lane_q, lane_d;
    logic [23:0]                word_q, word_d;
    logic [7:0]                 csum_q, csum_d;
    logic [PMEM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]                data_q, data_d;
    logic                       wen_q, wen_d;
    logic                       last_q, last_d;
    logic                       start_frame;
    logic [15:0]                len_full;
    logic [16:0]                wcnt_inc;

    uart_rx #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .BAUD        (BAUD)
    ) u_rx (
        .clk_i         (sysclk),
        .rst_i         (rst),
        .rx_i          (uart_rx),
        .byte_o        (rx_byte),
        .byte_valid_o  (rx_valid),
        .framing_err_o (rx_ferr)
    );

    assign len_full = {rx_byte, len_q[7:0]};
    assign wcnt_inc = wcnt_q + 17'd1;

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            wcnt_q  <= '0;
            lane_q  <= '0;
            word_q  <= '0;
            csum_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wen_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            wcnt_q  <= wcnt_d;
            lane_q  <= lane_d;
            word_q  <= word_d;
            csum_q  <= csum_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wen_q   <= wen_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        wcnt_d      = wcnt_q;
        lane_d      = lane_q;
        word_d      = word_q;
        csum_d      = csum_q;
        addr_d      = addr_q;
        data_d      = data_q;
        wen_d       = 1'b0;
        last_d      = last_q;
        start_frame = 1'b0;

        // The address holds on the final word so it never wraps at full capacity.
        if (wen_q && !last_q) begin
            addr_d = addr_q + PMEM_ADDR_WIDTH'(1);
        end

        if (rx_ferr) begin
            if (state_q inside {LEN0, LEN1, DATA, CSUM}) begin
                state_d = ERROR;
            end
        end else if (rx_valid) begin
            case (state_q)
                IDLE, ERROR: begin
                    if (rx_byte == SYNC_BYTE) start_frame = 1'b1;
                end
                DONE: begin
`ifdef LOADER_RELOAD_EN
                    if (rx_byte == SYNC_BYTE) start_frame = 1'b1;
`endif
                end
                LEN0: begin
                    len_d[7:0] = rx_byte;
                    state_d    = LEN1;
                end
                LEN1: begin
                    len_d = len_full;
                    if ({1'b0, len_full} > CAPACITY) begin
                        state_d = ERROR;
                    end else if (len_full == 16'd0) begin
                        state_d = CSUM;
                    end else begin
                        state_d = DATA;
                    end
                end
                DATA: begin
                    csum_d = csum_q ^ rx_byte;
                    word_d = {rx_byte, word_q[23:8]};
                    lane_d = lane_q + lane_t'(1);
                    if (&lane_q) begin
                        data_d = {rx_byte, word_q};
                        wen_d  = 1'b1;
                        last_d = (wcnt_inc == {1'b0, len_q});
                        wcnt_d = wcnt_inc;
                        if (wcnt_inc == {1'b0, len_q}) begin
                            state_d = CSUM;
                        end
                    end
                end
                CSUM: begin
                    state_d = (rx_byte == csum_q) ? DONE : ERROR;
                end
                default: state_d = IDLE;
            endcase
        end

        if (start_frame) begin
            state_d = LEN0;
            csum_d  = '0;
            wcnt_d  = '0;
            lane_d  = '0;
            word_d  = '0;
            addr_d  = '0;
            last_d  = 1'b0;
        end
    end

    assign pmem_wr_addr   = addr_q;
    assign pmem_wr_data   = data_q;
    assign pmem_byte_w_en = wen_q ? 4'hF : 4'h0;
    assign cpu_rst        = (state_q != DONE);
    assign load_done      = (state_q == DONE);
    assign load_error     = (state_q == ERROR);

endmodule

// File: tb/tb_uart_program_loader.sv
// Self-checking bench for uart_program_loader: directed and random frames checked against a frame-parsing reference model.
module tb_uart_program_loader;

    localparam int CLK_FREQ_HZ = 1000000;
    localparam int BAUD        = 100000;
    localparam int DIV         = CLK_FREQ_HZ / BAUD;
    localparam int AW          = 12;
    localparam int WR_W        = AW + 32;
`ifdef LOADER_RELOAD_EN
    localparam bit RELOAD = 1'b1;
`else
    localparam bit RELOAD = 1'b0;
`endif
    localparam int M_IDLE = 0, M_BUSY = 1, M_DONE = 2, M_ERROR = 3;

    // ---------------- clock / reset / DUT
    logic          sysclk  = 1'b0;
    logic          rst     = 1'b1;
    logic          uart_rx = 1'b1;
    logic [AW-1:0] pmem_wr_addr;
    logic [31:0]   pmem_wr_data;
    logic [3:0]    pmem_byte_w_en;
    logic          cpu_rst;
    logic          load_done;
    logic          load_error;

    always #5 sysclk = ~sysclk;

    uart_program_loader #(
        .CLK_FREQ_HZ     (CLK_FREQ_HZ),
        .BAUD            (BAUD),
        .PMEM_ADDR_WIDTH (AW)
    ) dut (
        .sysclk         (sysclk),
        .rst            (rst),
        .uart_rx        (uart_rx),
        .pmem_wr_addr   (pmem_wr_addr),
        .pmem_wr_data   (pmem_wr_data),
        .pmem_byte_w_en (pmem_byte_w_en),
        .cpu_rst        (cpu_rst),
        .load_done      (load_done),
        .load_error     (load_error)
    );

    // ---------------- bench state
    typedef struct packed {
        logic       fe;
        logic [7:0] b;
    } tok_t;

    tok_t            toks[$];
    logic [7:0]      frame_q[$];
    logic [WR_W-1:0] exp_q[$];
    logic [WR_W-1:0] obs_q[$];
    logic [31:0]     mem [0:(1<<AW)-1];
    int              n_checks = 0;
    int              n_errors = 0;
    int              we_run   = 0;
    int              n_valid  = 0;
    int              m_pos;
    int              m_status;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- write monitor (program-memory stand-in)
    always @(negedge sysclk) begin
        if (!rst) begin
            if (dut.rx_valid) n_valid++;
            if (pmem_byte_w_en != 4'h0) begin
                check("we_value", 64'(pmem_byte_w_en), 64'hF);
                obs_q.push_back({pmem_wr_addr, pmem_wr_data});
                mem[pmem_wr_addr] = pmem_wr_data;
                we_run++;
            end else if (we_run != 0) begin
                check("we_pulse_len", 64'(we_run), 64'd1);
                we_run = 0;
            end
        end
    end

    // ---------------- reference model: parse the byte stream since the last reset
    function automatic bit m_next(output logic [7:0] b);
        b = 8'h00;
        if (m_pos >= toks.size()) return 1'b0;
        b = toks[m_pos].b;
        m_pos++;
        if (toks[m_pos-1].fe) begin
            m_status = M_ERROR;
            return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_frame();
        logic [7:0]  lo, hi, b, x;
        logic [31:0] word;
        int          n;
        m_status = M_BUSY;
        if (!m_next(lo)) return;
        if (!m_next(hi)) return;
        n = int'({hi, lo});
        if (n > (1 << AW)) begin
            m_status = M_ERROR;
            return;
        end
        x = 8'h00;
        for (int w = 0; w < n; w++) begin
            word = 32'h0;
            for (int k = 0; k < 4; k++) begin
                if (!m_next(b)) return;
                word[8*k +: 8] = b;
                x = x ^ b;
            end
            exp_q.push_back({AW'(w), word});
        end
        if (!m_next(b)) return;
        m_status = (b == x) ? M_DONE : M_ERROR;
    endtask

    task automatic model_run();
        tok_t t;
        m_status = M_IDLE;
        m_pos    = 0;
        exp_q.delete();
        while (m_pos < toks.size()) begin
            t = toks[m_pos];
            m_pos++;
            if (!t.fe && t.b == 8'hA5 && (m_status != M_DONE || RELOAD)) model_frame();
        end
    endtask

    // ---------------- driver tasks
    task automatic apply_reset();
        @(negedge sysclk);
        rst = 1'b1;
        #1;
        check("rst_cpu_rst", 64'(cpu_rst), 64'd1);
        check("rst_load_done", 64'(load_done), 64'd0);
        check("rst_load_error", 64'(load_error), 64'd0);
        check("rst_we", 64'(pmem_byte_w_en), 64'd0);
        check("rst_addr", 64'(pmem_wr_addr), 64'd0);
        check("rst_data", 64'(pmem_wr_data), 64'd0);
        repeat (3) @(negedge sysclk);
        toks.delete();
        obs_q.delete();
        we_run = 0;
        rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        toks.push_back({bad_stop, b});
        @(negedge sysclk);
        uart_rx = 1'b0;
        repeat (DIV) @(negedge sysclk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (DIV) @(negedge sysclk);
        end
        uart_rx = !bad_stop;
        repeat (DIV) @(negedge sysclk);
        uart_rx = 1'b1;
        repeat (2 * DIV) @(negedge sysclk);
    endtask

    task automatic send_frame(input int bad_idx);
        for (int i = 0; i < frame_q.size(); i++) send_byte(frame_q[i], i == bad_idx);
    endtask

    task automatic build_frame(input int n, input bit bad_csum);
        logic [7:0] x, b;
        frame_q = '{8'hA5, 8'(n), 8'(n >> 8)};
        x = 8'h00;
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom_range(0, 255));
            frame_q.push_back(b);
            x = x ^ b;
        end
        if (bad_csum) x = x ^ 8'($urandom_range(1, 255));
        frame_q.push_back(x);
    endtask

    task automatic build_words(input int n, input logic [31:0] w0, input logic [31:0] w1, input bit zero_csum);
        logic [31:0] w;
        logic [7:0]  x;
        frame_q = '{8'hA5, 8'(n), 8'h00};
        x = 8'h00;
        for (int i = 0; i < n; i++) begin
            w = (i == 0) ? w0 : w1;
            for (int k = 0; k < 4; k++) begin
                frame_q.push_back(w[8*k +: 8]);
                x = x ^ w[8*k +: 8];
            end
        end
        frame_q.push_back(zero_csum ? 8'h00 : x);
    endtask

    // ---------------- scoreboard checkpoint
    task automatic check_point(input string tag);
        repeat (2 * DIV) @(negedge sysclk);
        model_run();
        check({tag, "_cpu_rst"}, 64'(cpu_rst), 64'(m_status != M_DONE));
        check({tag, "_done"}, 64'(load_done), 64'(m_status == M_DONE));
        check({tag, "_error"}, 64'(load_error), 64'(m_status == M_ERROR));
        check({tag, "_nwr"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check({tag, "_wr"}, 64'(obs_q[i]), 64'(exp_q[i]));
    endtask

    // ---------------- stimulus
    initial begin
        int          kind, n, v0;
        logic [7:0]  jb;
        logic [31:0] w;

        apply_reset();

        build_words(2, 32'h12345678, 32'hDEADBEEF, 1'b0);
        send_frame(-1);
        check_point("good2");
        check("good2_mem0", 64'(mem[0]), 64'h12345678);
        check("good2_mem1", 64'(mem[1]), 64'hDEADBEEF);

        build_words(1, 32'hDDCCBBAA, 32'h0, 1'b1);
        send_byte(frame_q[0], 1'b0);
        check_point("after_done_sync");
        for (int i = 1; i < frame_q.size(); i++) send_byte(frame_q[i], 1'b0);
        check_point("after_done_frame");

        apply_reset();
        build_words(2, 32'h12345678, 32'hDEADBEEF, 1'b1);
        send_frame(-1);
        check_point("bad_csum");
        build_words(2, 32'h12345678, 32'hDEADBEEF, 1'b0);
        send_frame(-1);
        check_point("recover");

        apply_reset();
        build_frame(0, 1'b0);
        send_frame(-1);
        check_point("n0");

        apply_reset();
        frame_q = '{8'hA5, 8'h01, 8'h10};
        send_frame(-1);
        check_point("n4097");

        apply_reset();
        frame_q = '{8'hA5, 8'h00, 8'h10};
        send_frame(-1);
        check_point("n4096");

        apply_reset();
        build_frame(2, 1'b0);
        send_frame(5);
        check_point("ferr_payload");

        apply_reset();
        v0 = n_valid;
        @(negedge sysclk);
        uart_rx = 1'b0;
        repeat (3) @(negedge sysclk);
        uart_rx = 1'b1;
        repeat (3 * DIV) @(negedge sysclk);
        check("glitch_no_valid", 64'(n_valid - v0), 64'd0);
        build_frame(1, 1'b0);
        send_frame(-1);
        check_point("post_glitch");

        apply_reset();
        w = $urandom;
        build_words(2, w, 32'hCAFEF00D, 1'b0);
        for (int i = 0; i < 8; i++) send_byte(frame_q[i], 1'b0);
        check_point("partial");
        apply_reset();
        check("rst_keeps_mem0", 64'(mem[0]), 64'(w));

        for (int it = 0; it < 6; it++) begin
            apply_reset();
            repeat ($urandom_range(0, 2)) begin
                jb = 8'($urandom_range(0, 255));
                if (jb == 8'hA5) jb = 8'h5A;
                send_byte(jb, 1'b0);
            end
            kind = $urandom_range(0, 3);
            n    = $urandom_range(1, 3);
            case (kind)
                0: begin build_frame(n, 1'b0); send_frame(-1); end
                1: begin build_frame(n, 1'b1); send_frame(-1); end
                2: begin build_frame(n, 1'b0); send_frame($urandom_range(1, 4 * n + 3)); end
                default: begin
                    n = $urandom_range(4097, 65535);
                    frame_q = '{8'hA5, 8'(n), 8'(n >> 8)};
                    send_frame(-1);
                end
            endcase
            check_point("rand_a");
            build_frame($urandom_range(0, 2), 1'b0);
            send_frame(-1);
            check_point("rand_b");
            build_frame(1, 1'b0);
            send_frame(-1);
            check_point("rand_c");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
